// File: rtl/clk_gen_ctrl.sv
`timescale 1ns/1ps
// clk_gen_ctrl: run-time programmable divided clock for the single-cycle core.
// Latency: first o_clk_div rise one i_clk after RUN is seen in IDLE; all outputs registered.
// Backpressure: none; mode changes take effect only at period boundaries (no runt pulses).
//
// Ports:
//   i_clk        board clock, all logic on its rising edge
//   i_reset      asynchronous active-low reset
//   i_div        requested half-period (0 treated as 1), captured by i_div_load
//   i_div_load   one-cycle strobe writing i_div into the shadow divisor
//   i_mode       00 RUN, 01 STEP, 10/11 HALT
//   i_step       raw, bouncing step push-button (active high)
//   o_clk_div    50% duty divided clock
//   o_clk_en     one-cycle pulse in the first high cycle of o_clk_div
//   o_div_active half-period currently in use
//   o_tick_cnt   number of o_clk_en pulses since reset (wraps)
//   o_state      debug FSM state: 00 IDLE, 01 HI, 10 LO
module clk_gen_ctrl #(
  parameter int CNT_W       = 16,
  parameter int DEFAULT_DIV = 25,
  parameter int DBNC_CYCLES = 50000,
  parameter int TICK_W      = 32
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [CNT_W-1:0]  i_div,
  input  logic              i_div_load,
  input  logic [1:0]        i_mode,
  input  logic              i_step,
  output logic              o_clk_div,
  output logic              o_clk_en,
  output logic [CNT_W-1:0]  o_div_active,
  output logic [TICK_W-1:0] o_tick_cnt,
  output logic [1:0]        o_state
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    HI   = 2'b01,
    LO   = 2'b10
  } state_t;

  // A zero divisor would never reach terminal count, so clamp to 1.
  localparam int DEF_N = (DEFAULT_DIV < 1) ? 1 : DEFAULT_DIV;
  localparam logic [CNT_W-1:0] DEF_DIV = CNT_W'(DEF_N);

  localparam int DBNC_N = (DBNC_CYCLES < 1) ? 1 : DBNC_CYCLES;
  localparam int DW     = $clog2(DBNC_N + 1);
  localparam logic [DW-1:0] DBNC_LAST = DW'(DBNC_N - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] shadow;
  logic             pending;

  logic             step_meta;
  logic             step_sync;
  logic             step_lvl;
  logic             step_lvl_q;
  logic [DW-1:0]    dbnc_cnt;
  logic             step_pulse;

  logic             mode_run;
  logic             mode_step;
  logic             tc;
  logic             enter_hi;
  logic [CNT_W-1:0] div_req;

  assign o_state    = state;
  assign mode_run   = (i_mode == 2'b00);
  assign mode_step  = (i_mode == 2'b01);
  assign tc         = (cnt == o_div_active - CNT_W'(1));
  assign div_req    = (i_div == '0) ? CNT_W'(1) : i_div;
  assign step_pulse = step_lvl & ~step_lvl_q;

  // Every rising edge of o_clk_div comes through here; it is also the only
  // point where a pending divisor is applied, keeping both halves equal.
  always_comb begin
    enter_hi = 1'b0;
    case (state)
      IDLE:    enter_hi = mode_run | (mode_step & step_pulse);
      LO:      enter_hi = tc & mode_run;
      default: enter_hi = 1'b0;
    endcase
  end

  // Step button: 2-FF synchroniser, then the accepted level only moves after
  // DBNC_N consecutive samples that disagree with it. A sample agreeing with
  // the current level restarts the count.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      step_meta  <= 1'b0;
      step_sync  <= 1'b0;
      step_lvl   <= 1'b0;
      step_lvl_q <= 1'b0;
      dbnc_cnt   <= '0;
    end else begin
      step_meta  <= i_step;
      step_sync  <= step_meta;
      step_lvl_q <= step_lvl;
      if (step_sync == step_lvl) begin
        dbnc_cnt <= '0;
      end else if (dbnc_cnt == DBNC_LAST) begin
        step_lvl <= step_sync;
        dbnc_cnt <= '0;
      end else begin
        dbnc_cnt <= dbnc_cnt + DW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state        <= IDLE;
      cnt          <= '0;
      o_clk_div    <= 1'b0;
      o_clk_en     <= 1'b0;
      o_tick_cnt   <= '0;
      o_div_active <= DEF_DIV;
      shadow       <= DEF_DIV;
      pending      <= 1'b0;
    end else begin
      o_clk_en <= 1'b0;

      // A load in the same cycle as the apply stays pending for the next rise;
      // the apply itself uses the shadow value from before this load.
      if (i_div_load) begin
        shadow <= div_req;
      end
      pending <= i_div_load | (pending & ~enter_hi);

      if (enter_hi) begin
        state      <= HI;
        cnt        <= '0;
        o_clk_div  <= 1'b1;
        o_clk_en   <= 1'b1;
        o_tick_cnt <= o_tick_cnt + TICK_W'(1);
        if (pending) begin
          o_div_active <= shadow;
        end
      end else begin
        case (state)
          IDLE: begin
            cnt       <= '0;
            o_clk_div <= 1'b0;
          end
          HI: begin
            if (tc) begin
              cnt       <= '0;
              state     <= LO;
              o_clk_div <= 1'b0;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          LO: begin
            // LO terminal count with RUN is handled by enter_hi above.
            if (tc) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
          default: begin
            state     <= IDLE;
            cnt       <= '0;
            o_clk_div <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
